// File: rtl/fifo_level_pkg.sv
// ---------------------------------------------------------------------------
// fifo_level_pkg
// Shared helpers for the fifo_level stream FIFO:
//   - parameter checkers used at elaboration time to reject illegal configs
//   - width helpers for the occupancy counter and the ring-buffer pointers
// No ports (package).
// ---------------------------------------------------------------------------
package fifo_level_pkg;

    // True when v is a positive integer (>= 1).
    function automatic bit check_param_pos(input int v);
        return v >= 1;
    endfunction

    // True when v is a non-negative integer (>= 0).
    function automatic bit check_param_nonneg(input int v);
        return v >= 0;
    endfunction

    // True when lo <= v <= hi.
    function automatic bit check_param_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Bits needed to hold an occupancy of 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed for a pointer over 0..n-1; never less than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_level_if.sv
// ---------------------------------------------------------------------------
// fifo_level_if
// Valid/ready stream bundle around the FIFO: the enqueue side (i_valid,
// i_ready, i) and the dequeue side (o_valid, o_ready, o).
//   master : the surrounding logic (producer drives i_valid/i, consumer
//            drives o_ready)
//   slave  : the FIFO itself
// Parameter W: item width in bits.
// ---------------------------------------------------------------------------
interface fifo_level_if #(
    parameter int W = 1
);
    logic         i_valid;
    logic         i_ready;
    logic [W-1:0] i;
    logic         o_valid;
    logic         o_ready;
    logic [W-1:0] o;

    modport master (
        output i_valid, i, o_ready,
        input  i_ready, o_valid, o
    );

    modport slave (
        input  i_valid, i, o_ready,
        output i_ready, o_valid, o
    );
endinterface

// File: rtl/fifo_level_wrap_ctr.sv
// ---------------------------------------------------------------------------
// fifo_level_wrap_ctr
// Modulo-N pointer for the FIFO ring buffer. Wraps N-1 -> 0 by explicit
// compare so that non-power-of-two depths work.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high clear to 0 (dominant over clk_en)
//   clk_en : clock enable; pointer holds when low
//   inc    : advance pointer by one
//   q      : current pointer value 0..N-1
// ---------------------------------------------------------------------------
module fifo_level_wrap_ctr
    import fifo_level_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    inc,
    output logic [ptr_width(N)-1:0] q
);
    localparam int PW = ptr_width(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (clk_en && inc) begin
            q_reg <= (q_reg == LAST) ? '0 : q_reg + PW'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fifo_level.sv
// ---------------------------------------------------------------------------
// fifo_level
// First-word-fall-through valid/ready FIFO of any depth N >= 1 with an
// occupancy count and registered almost-full / almost-empty flags.
// Items live in a distributed-RAM style array (combinational read at the
// read pointer) or, for N == 1, in a single register.
//
// Parameters: W item width, N depth, AF almost-full threshold (count >= AF),
//             AE almost-empty threshold (count <= AE).
// Ports:
//   clk, rst      : clock, synchronous active-high reset (dominant)
//   clk_en        : clock enable; all registers hold when low
//   flush         : (only with CFU_FIFO_FLUSH_EN) empties the FIFO like rst,
//                   qualified by clk_en; drops a same-cycle enqueue
//   s             : stream bundle (i_valid/i_ready/i, o_valid/o_ready/o)
//   count         : registered occupancy 0..N
//   almost_full   : registered, count >= AF
//   almost_empty  : registered, count <= AE
// Optional feature macro: CFU_FIFO_FLUSH_EN.
// ---------------------------------------------------------------------------
module fifo_level
    import fifo_level_pkg::*;
#(
    parameter int W  = 1,
    parameter int N  = 4,
    parameter int AF = N - 1,
    parameter int AE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
`ifdef CFU_FIFO_FLUSH_EN
    input  logic                   flush,
`endif
    fifo_level_if.slave            s,
    output logic [$clog2(N+1)-1:0] count,
    output logic                   almost_full,
    output logic                   almost_empty
);
    localparam int CW = count_width(N);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t N_C  = cnt_t'(N);
    localparam cnt_t AF_C = cnt_t'(AF);
    localparam cnt_t AE_C = cnt_t'(AE);

    // Elaboration-time parameter checks.
    if (!check_param_pos(W)) begin : g_bad_w
        $error("fifo_level: W must be >= 1");
    end
    if (!check_param_pos(N)) begin : g_bad_n
        $error("fifo_level: N must be >= 1");
    end
    if (!check_param_range(AF, 1, N)) begin : g_bad_af
        $error("fifo_level: AF must be in 1..N");
    end
    if (!check_param_nonneg(AE) || !check_param_range(AE, 0, N - 1)) begin : g_bad_ae
        $error("fifo_level: AE must be in 0..N-1");
    end

    cnt_t count_reg;
    cnt_t count_next;
    logic o_valid_reg;
    logic almost_full_reg;
    logic almost_empty_reg;

    logic full;
    logic enq;
    logic deq;
    logic clear;

    // clear empties the FIFO; flush only counts on an enabled edge while rst
    // wins regardless of clk_en.
`ifdef CFU_FIFO_FLUSH_EN
    assign clear = rst || (clk_en && flush);
`else
    assign clear = rst;
`endif

    assign full      = (count_reg == N_C);
    // When full, a consumer taking the head frees a slot in the same edge,
    // so o_ready is forwarded to the producer.
    assign s.i_ready = !full || s.o_ready;
    assign s.o_valid = o_valid_reg;

    assign enq = s.i_valid && s.i_ready;
    assign deq = o_valid_reg && s.o_ready;

    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + cnt_t'(1);
            2'b01:   count_next = count_reg - cnt_t'(1);
            default: count_next = count_reg;
        endcase
    end

    // Flags are derived from count_next so they line up with count.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg        <= '0;
            o_valid_reg      <= 1'b0;
            almost_full_reg  <= (AF == 0);
            almost_empty_reg <= 1'b1;
        end else if (clk_en) begin
            count_reg        <= count_next;
            o_valid_reg      <= (count_next != '0);
            almost_full_reg  <= (count_next >= AF_C);
            almost_empty_reg <= (count_next <= AE_C);
        end
    end

    assign count        = count_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;

    // Storage. Contents are never reset: o_valid/count gate their meaning.
    // A write while clear is active is harmless because the count goes to 0.
    if (N == 1) begin : g_single
        logic [W-1:0] data_reg;

        always_ff @(posedge clk) begin
            if (clk_en && enq) begin
                data_reg <= s.i;
            end
        end

        assign s.o = data_reg;
    end else begin : g_ring
        localparam int PW = ptr_width(N);

        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [W-1:0]  mem [N];

        fifo_level_wrap_ctr #(.N(N)) u_wr_ptr (
            .clk    (clk),
            .rst    (clear),
            .clk_en (clk_en),
            .inc    (enq),
            .q      (wr_ptr)
        );

        fifo_level_wrap_ctr #(.N(N)) u_rd_ptr (
            .clk    (clk),
            .rst    (clear),
            .clk_en (clk_en),
            .inc    (deq),
            .q      (rd_ptr)
        );

        // When full with enq and deq together, wr_ptr == rd_ptr: the head is
        // read combinationally this cycle and overwritten at the edge.
        always_ff @(posedge clk) begin
            if (clk_en && enq) begin
                mem[wr_ptr] <= s.i;
            end
        end

        assign s.o = mem[rd_ptr];
    end

endmodule

// File: tb/tb_fifo_level.sv
// ---------------------------------------------------------------------------
// tb_fifo_level
// Table-driven bench for fifo_level. Two instances share the clock:
//   dut_a : W=8,  N=5, AF=4, AE=1 (non-power-of-two ring)
//   dut_b : W=32, N=1, AF=1, AE=0 (single-register storage)
// Each vector drives inputs, checks the combinational i_ready before the
// edge, then checks the registered state (and head item) just after it.
// ---------------------------------------------------------------------------
module tb_fifo_level;

    typedef struct {
        logic        rst;
        logic        en;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] din;
        logic        exp_ir;
        logic        exp_ov;
        int          exp_cnt;
        logic        exp_af;
        logic        exp_ae;
        logic [31:0] exp_o;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, en_a, rst_b, en_b;
    logic fl_a, fl_b;
    logic [2:0] cnt_a;
    logic [0:0] cnt_b;
    logic af_a, ae_a, af_b, ae_b;

    fifo_level_if #(.W(8))  ifa ();
    fifo_level_if #(.W(32)) ifb ();

    fifo_level #(.W(8), .N(5), .AF(4), .AE(1)) dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .clk_en       (en_a),
`ifdef CFU_FIFO_FLUSH_EN
        .flush        (fl_a),
`endif
        .s            (ifa),
        .count        (cnt_a),
        .almost_full  (af_a),
        .almost_empty (ae_a)
    );

    fifo_level #(.W(32), .N(1), .AF(1), .AE(0)) dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .clk_en       (en_b),
`ifdef CFU_FIFO_FLUSH_EN
        .flush        (fl_b),
`endif
        .s            (ifb),
        .count        (cnt_b),
        .almost_full  (af_b),
        .almost_empty (ae_b)
    );

    int checks   = 0;
    int failures = 0;

    vec_t va[$];
    vec_t vb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input int which,
                        input logic rst, input logic en, input logic fl,
                        input logic iv, input logic ordy, input logic [31:0] din,
                        input logic ir, input logic ov, input int cnt,
                        input logic af, input logic ae, input logic [31:0] o);
        vec_t v;
        v.rst = rst; v.en = en; v.fl = fl; v.iv = iv; v.ordy = ordy; v.din = din;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_cnt = cnt;
        v.exp_af = af; v.exp_ae = ae; v.exp_o = o;
        if (which == 0) va.push_back(v);
        else            vb.push_back(v);
    endtask

    task automatic apply(input int which, input int idx, input vec_t v);
        string       tag;
        logic        ir, ov, af, ae;
        logic [31:0] o;
        int          cnt;
        tag = $sformatf("%s[%0d]", (which == 0) ? "A" : "B", idx);
        if (which == 0) begin
            rst_a = v.rst; en_a = v.en; fl_a = v.fl;
            ifa.i_valid = v.iv; ifa.o_ready = v.ordy; ifa.i = v.din[7:0];
        end else begin
            rst_b = v.rst; en_b = v.en; fl_b = v.fl;
            ifb.i_valid = v.iv; ifb.o_ready = v.ordy; ifb.i = v.din;
        end
        #1;
        ir = (which == 0) ? ifa.i_ready : ifb.i_ready;
        check({tag, ".i_ready"}, {31'b0, ir}, {31'b0, v.exp_ir});
        @(posedge clk);
        #1;
        if (which == 0) begin
            ov = ifa.o_valid; cnt = int'(cnt_a); af = af_a; ae = ae_a; o = {24'b0, ifa.o};
        end else begin
            ov = ifb.o_valid; cnt = int'(cnt_b); af = af_b; ae = ae_b; o = ifb.o;
        end
        $display("%s rst=%0b en=%0b fl=%0b iv=%0b ordy=%0b din=%0h -> ov=%0b cnt=%0d af=%0b ae=%0b o=%0h",
                 tag, v.rst, v.en, v.fl, v.iv, v.ordy, v.din, ov, cnt, af, ae, o);
        check({tag, ".o_valid"}, {31'b0, ov}, {31'b0, v.exp_ov});
        check({tag, ".count"}, cnt, v.exp_cnt);
        check({tag, ".almost_full"}, {31'b0, af}, {31'b0, v.exp_af});
        check({tag, ".almost_empty"}, {31'b0, ae}, {31'b0, v.exp_ae});
        if (v.exp_ov) check({tag, ".o"}, o, v.exp_o);
    endtask

    initial begin
        // ---------------- vectors for dut_a (N=5, AF=4, AE=1) ----------------
        // reset state
        addv(0, 1,1,0, 0,0,32'h0,  1,0,0,0,1,32'h0);
        // fill 0x11..0x15 with o_ready=0; head stays 0x11
        for (int k = 0; k < 5; k++)
            addv(0, 0,1,0, 1,0,32'h11 + k, 1,1,k+1, (k+1 >= 4), (k+1 <= 1), 32'h11);
        // full: i_ready=0, offered item refused
        addv(0, 0,1,0, 1,0,32'h16, 0,1,5,1,0,32'h11);
        // drain 5
        for (int k = 0; k < 5; k++)
            addv(0, 0,1,0, 0,1,32'h0, 1,(k < 4),4-k,(4-k >= 4),(4-k <= 1),32'h12 + k);
        // refill 0x20..0x24
        for (int k = 0; k < 5; k++)
            addv(0, 0,1,0, 1,0,32'h20 + k, 1,1,k+1,(k+1 >= 4),(k+1 <= 1),32'h20);
        // full streaming 12 cycles across the 4->0 wrap
        for (int k = 0; k < 12; k++)
            addv(0, 0,1,0, 1,1,32'h30 + k, 1,1,5,1,0,
                 (k < 4) ? 32'h21 + k : 32'h30 + k - 4);
        // drain the remaining 0x37..0x3B
        for (int k = 0; k < 5; k++)
            addv(0, 0,1,0, 0,1,32'h0, 1,(k < 4),4-k,(4-k >= 4),(4-k <= 1),32'h38 + k);
        // single enqueue of 0xA5 into empty
        addv(0, 0,1,0, 1,0,32'hA5, 1,1,1,0,1,32'hA5);
        // clk_en=0 with pending dequeue: frozen
        for (int k = 0; k < 3; k++)
            addv(0, 0,0,0, 0,1,32'h0, 1,1,1,0,1,32'hA5);
        // clk_en=0 with pending enqueue: frozen
        addv(0, 0,0,0, 1,0,32'h5A, 1,1,1,0,1,32'hA5);
        addv(0, 0,1,0, 0,1,32'h0, 1,0,0,0,1,32'h0);
        // rst dominant over clk_en=0
        addv(0, 0,1,0, 1,0,32'h55, 1,1,1,0,1,32'h55);
        addv(0, 1,0,0, 1,0,32'h56, 1,0,0,0,1,32'h0);
        addv(0, 0,1,0, 0,0,32'h0, 1,0,0,0,1,32'h0);
        // rst at count=3 with i_valid=1
        for (int k = 0; k < 3; k++)
            addv(0, 0,1,0, 1,0,32'h61 + k, 1,1,k+1,0,(k == 0),32'h61);
        addv(0, 1,1,0, 1,0,32'h64, 1,0,0,0,1,32'h0);
        addv(0, 0,1,0, 0,0,32'h0, 1,0,0,0,1,32'h0);
        // pointers were cleared: a fresh item is the head
        addv(0, 0,1,0, 1,0,32'h70, 1,1,1,0,1,32'h70);
        addv(0, 0,1,0, 0,1,32'h0, 1,0,0,0,1,32'h0);
`ifdef CFU_FIFO_FLUSH_EN
        // flush at count=3 with i_valid=1: same-cycle item dropped
        for (int k = 0; k < 3; k++)
            addv(0, 0,1,0, 1,0,32'h71 + k, 1,1,k+1,0,(k == 0),32'h71);
        addv(0, 0,1,1, 1,0,32'h74, 1,0,0,0,1,32'h0);
        addv(0, 0,1,0, 0,1,32'h0, 1,0,0,0,1,32'h0);
        addv(0, 0,1,0, 1,0,32'h75, 1,1,1,0,1,32'h75);
        addv(0, 0,1,0, 0,1,32'h0, 1,0,0,0,1,32'h0);
`endif

        // ---------------- vectors for dut_b (N=1, AF=1, AE=0) ----------------
        addv(1, 1,1,0, 0,0,32'h0,        1,0,0,0,1,32'h0);
        addv(1, 0,1,0, 1,1,32'hDEAD0001, 1,1,1,1,0,32'hDEAD0001);
        addv(1, 0,1,0, 1,1,32'hDEAD0002, 1,1,1,1,0,32'hDEAD0002);
        addv(1, 0,1,0, 1,1,32'hDEAD0003, 1,1,1,1,0,32'hDEAD0003);
        addv(1, 0,1,0, 0,1,32'h0,        1,0,0,0,1,32'h0);
        addv(1, 0,1,0, 1,0,32'hCAFE0004, 1,1,1,1,0,32'hCAFE0004);
        addv(1, 0,1,0, 1,0,32'hCAFE0005, 0,1,1,1,0,32'hCAFE0004);
        addv(1, 0,1,0, 0,1,32'h0,        1,0,0,0,1,32'h0);
        addv(1, 0,1,0, 1,0,32'hBEEF0006, 1,1,1,1,0,32'hBEEF0006);
        addv(1, 0,1,0, 0,1,32'h0,        1,0,0,0,1,32'h0);

        // initial reset of both instances
        rst_a = 1'b1; en_a = 1'b1; fl_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b1; fl_b = 1'b0;
        ifa.i_valid = 1'b0; ifa.o_ready = 1'b0; ifa.i = '0;
        ifb.i_valid = 1'b0; ifb.o_ready = 1'b0; ifb.i = '0;
        @(posedge clk);
        #1;

        // dut_b idles in reset while dut_a runs, and vice versa
        foreach (va[k]) apply(0, k, va[k]);
        rst_a = 1'b1;
        foreach (vb[k]) apply(1, k, vb[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
